reg_file_mp: RTL and testbench
==============================

// Module: reg_file_mp
// PURPOSE
//  Parametrised multi-port register file: next generation of the CPU 16x16 regfile.
//  Adds NUM_RD read ports, two write ports (A = ALU, B = load/secondary result) with
//  fixed priority, optional same-cycle write-to-read bypass, and a per-register
//  busy scoreboard for hazard detection. Sits between decode (reads, scoreboard set)
//  and writeback (write ports) of the datapath.
// PARAMETERS
//  DATA_W      16             register width in bits
//  ADDR_W      4              address width; DEPTH = 1<<ADDR_W registers
//  NUM_RD      3              number of read ports
//  BYPASS      1              1: reads return same-cycle write data; 0: registered value only
//  ZERO_R0     0              1: register 0 is hard-wired zero (reads 0, writes/sets ignored)
//  RESET_IMAGE {DEPTH*DATA_W{0}}  reset contents; reg i = RESET_IMAGE[i*DATA_W +: DATA_W]
// PORTS
//  clk          in   1               clock, rising edge
//  rst          in   1               reset, asynchronous, active-low
//  rd_addr      in   NUM_RD*ADDR_W   read addresses, port k at [k*ADDR_W +: ADDR_W]
//  rd_data      out  NUM_RD*DATA_W   read data, port k at [k*DATA_W +: DATA_W]
//  rd_busy      out  NUM_RD          scoreboard busy bit of each read address
//  wa_en        in   1               write port A enable (high priority)
//  wa_addr      in   ADDR_W          write port A address
//  wa_data      in   DATA_W          write port A data
//  wb_en        in   1               write port B enable (low priority)
//  wb_addr      in   ADDR_W          write port B address
//  wb_data      in   DATA_W          write port B data
//  sb_set       in   1               mark sb_addr busy (producer issued)
//  sb_addr      in   ADDR_W          scoreboard set address
//  busy_cnt     out  ADDR_W+1        number of busy registers (registered)
//  wr_conflict  out  1               registered pulse: A and B hit same address last cycle
// BEHAVIOUR
//  Reset (rst=0, async): reg[i] <= RESET_IMAGE slice i; busy <= 0; busy_cnt <= 0;
//   wr_conflict <= 0. ZERO_R0=1 forces reg 0 to 0 regardless of RESET_IMAGE.
//  Writes: on posedge clk; data visible in registered state the next cycle.
//   - wa_en only: reg[wa_addr] <= wa_data. wb_en only: reg[wb_addr] <= wb_data.
//   - both, different addr: both written. Same addr: A written, B dropped,
//     wr_conflict = 1 for exactly the following cycle, else 0.
//   - ZERO_R0=1 and addr 0: write ignored, no conflict pulse.
//  Reads: combinational from rd_addr, zero latency.
//   - BYPASS=1: addr matches an enabled write -> that write's data (A before B);
//     BYPASS=0: current register contents. ZERO_R0=1 and addr 0 -> 0 always.
//   - Ports independent; any number may read the same address.
//  Scoreboard (busy[DEPTH]), updated at posedge clk:
//   - Enabled write on A or B clears busy[addr] (dropped B write still clears).
//   - sb_set sets busy[sb_addr]; set and clear on same addr same cycle -> set wins.
//   - sb_set on already-busy reg: stays busy (no counting of producers).
//   - ZERO_R0=1: busy[0] held 0.
//   - rd_busy[k] = busy[rd_addr[k]]; BYPASS=1 also deasserts when a same-cycle write
//     clears that addr and no same-cycle sb_set targets it.
//   - busy_cnt = popcount(busy) registered, updated same edge as busy; range 0..DEPTH.
//  Reset mid-operation discards pending writes and all busy state immediately.
//  X on addresses with enable low must not affect state.
// STRUCTURE
//  Shared package regfile_pkg: DATA_W/ADDR_W defaults, CPU default RESET_IMAGE
//   constant (r1=FFFF r2=0050 r3=F033 r4=F0FF r5=0040 r6=6666 r7=00FF r8=8888
//   r12=CCCC r13=0002, others 0), popcount function.
//  One sub-module: reg_scoreboard (busy vector, set/clear priority, busy_cnt).
//  Storage, write arbitration, bypass muxes stay in reg_file_mp (generate per read port).
// TESTING
//  1 Reset with default CPU image, read r1,r2,r12 on ports 0..2 -> FFFF,0050,CCCC;
//    busy_cnt=0.
//  2 wa_en addr 5 data 1234, rd_addr0=5 same cycle: BYPASS=1 -> 1234 that cycle;
//    BYPASS=0 -> 0040 then 1234 next cycle.
//  3 wa 7=AAAA and wb 7=BBBB same cycle -> r7=AAAA next cycle, wr_conflict=1 one cycle.
//  4 sb_set 3 -> rd_busy=1, busy_cnt=1; later wb_en 3 -> busy cleared, busy_cnt=0;
//    sb_set 3 + wa_en 3 same cycle -> stays busy, r3 updated.
//  5 ZERO_R0=1: wa 0=FFFF, sb_set 0 -> read 0 returns 0000, rd_busy=0, busy_cnt=0.
//  6 rst low mid-stream with 4 regs busy and writes pending -> image restored
//    immediately, busy_cnt=0, wr_conflict=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared regfile defaults, CPU reset image and popcount helper.
// Pure declarations: no latency, no backpressure.
package regfile_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int POP_MAX    = 256;

  // r15 down to r0; register i lives at [i*16 +: 16]
  localparam logic [16*16-1:0] CPU_RESET_IMAGE = {
    16'h0000, 16'h0000, 16'h0002, 16'hCCCC,
    16'h0000, 16'h0000, 16'h0000, 16'h8888,
    16'h00FF, 16'h6666, 16'h0040, 16'hF0FF,
    16'hF033, 16'h0050, 16'hFFFF, 16'h0000
  };

  function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard with registered busy count; set beats clear on the same address.
// Updates one edge after set/clear; no backpressure.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int ZERO_R0 = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clrAEn,
  input  logic [ADDR_W-1:0]        clrAAddr,
  input  logic                     clrBEn,
  input  logic [ADDR_W-1:0]        clrBAddr,
  input  logic                     setEn,
  input  logic [ADDR_W-1:0]        setAddr,
  output logic [(1<<ADDR_W)-1:0]   busy,
  output logic [ADDR_W:0]          busyCnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DEPTH-1:0]   busyNext;
  logic [POP_MAX-1:0] popExt;

  always_comb begin
    busyNext = busy;
    if (clrAEn) busyNext[clrAAddr] = 1'b0;
    if (clrBEn) busyNext[clrBAddr] = 1'b0;
    if (setEn)  busyNext[setAddr]  = 1'b1;
    if (ZERO_R0 != 0) busyNext[0] = 1'b0;
    popExt = '0;
    popExt[DEPTH-1:0] = busyNext;
  end

  // Count is taken from the next-state vector so it lands on the same edge as busy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy    <= '0;
      busyCnt <= '0;
    end else begin
      busy    <= busyNext;
      busyCnt <= CNT_W'(popcount(popExt));
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: two prioritised write ports, NUM_RD combinational reads, busy scoreboard.
// Reads zero latency (optional same-cycle bypass); writes visible next cycle; no backpressure.
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_RD  = 3,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0,
  parameter logic [(1<<ADDR_W)*DATA_W-1:0] RESET_IMAGE = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  output logic [ADDR_W:0]          busy_cnt,
  output logic                     wr_conflict
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              aOk, bOk, conflict, weA, weB;

  // Writes to a hard-wired r0 are dropped before arbitration, so they never conflict
  assign aOk      = wa_en && !((ZERO_R0 != 0) && (wa_addr == '0));
  assign bOk      = wb_en && !((ZERO_R0 != 0) && (wb_addr == '0));
  assign conflict = aOk && bOk && (wa_addr == wb_addr);
  assign weA      = aOk;
  assign weB      = bOk && !conflict;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= ((ZERO_R0 != 0) && (i == 0)) ? '0 : RESET_IMAGE[i*DATA_W +: DATA_W];
      end
      wr_conflict <= 1'b0;
    end else begin
      if (weA) regs[wa_addr] <= wa_data;
      if (weB) regs[wb_addr] <= wb_data;
      wr_conflict <= conflict;
    end
  end

  reg_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_R0 (ZERO_R0)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .clrAEn   (wa_en),
    .clrAAddr (wa_addr),
    .clrBEn   (wb_en),
    .clrBAddr (wb_addr),
    .setEn    (sb_set),
    .setAddr  (sb_addr),
    .busy     (busy),
    .busyCnt  (busy_cnt)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              busyBit;

    assign addr = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      data    = regs[addr];
      busyBit = busy[addr];
      if (BYPASS != 0) begin
        if (weB && (wb_addr == addr)) data = wb_data;
        if (weA && (wa_addr == addr)) data = wa_data;
        if (((wa_en && (wa_addr == addr)) || (wb_en && (wb_addr == addr))) &&
            !(sb_set && (sb_addr == addr)))
          busyBit = 1'b0;
      end
      if ((ZERO_R0 != 0) && (addr == '0)) data = '0;
    end

    assign rd_data[k*DATA_W +: DATA_W] = data;
    assign rd_busy[k] = busyBit;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: instance 0 bypass on / r0 normal, instance 1 bypass off / r0 zero.
module tb_reg_file_mp;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] rdAddr;
  logic        wa_en, wb_en, sb_set;
  logic [3:0]  wa_addr, wb_addr, sb_addr;
  logic [15:0] wa_data, wb_data;

  logic [47:0] rdDataA, rdDataB;
  logic [2:0]  rdBusyA, rdBusyB;
  logic [4:0]  cntA, cntB;
  logic        confA, confB;

  int nChecks = 0;
  int nFail   = 0;

  logic [15:0] mReg  [2][16];
  bit          mBusy [2][16];
  bit          mConf [2];
  int          byp   [2] = '{1, 0};
  int          zr    [2] = '{0, 1};

  always #5 clk = ~clk;

  reg_file_mp #(.BYPASS(1), .ZERO_R0(0), .RESET_IMAGE(CPU_RESET_IMAGE)) dutA (
    .clk(clk), .rst(rst), .rd_addr(rdAddr), .rd_data(rdDataA), .rd_busy(rdBusyA),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .sb_set(sb_set), .sb_addr(sb_addr), .busy_cnt(cntA), .wr_conflict(confA));

  reg_file_mp #(.BYPASS(0), .ZERO_R0(1), .RESET_IMAGE(CPU_RESET_IMAGE)) dutB (
    .clk(clk), .rst(rst), .rd_addr(rdAddr), .rd_data(rdDataB), .rd_busy(rdBusyB),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .sb_set(sb_set), .sb_addr(sb_addr), .busy_cnt(cntB), .wr_conflict(confB));

  function automatic logic [15:0] imgVal(int i);
    case (i)
      1: return 16'hFFFF;  2: return 16'h0050;  3: return 16'hF033;  4: return 16'hF0FF;
      5: return 16'h0040;  6: return 16'h6666;  7: return 16'h00FF;  8: return 16'h8888;
      12: return 16'hCCCC; 13: return 16'h0002;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic void modelReset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin
        mReg[d][i]  = (zr[d] != 0 && i == 0) ? 16'h0000 : imgVal(i);
        mBusy[d][i] = 1'b0;
      end
      mConf[d] = 1'b0;
    end
  endfunction

  function automatic int modelCount(int d);
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(mBusy[d][i]);
    return n;
  endfunction

  function automatic logic [15:0] expRead(int d, logic [3:0] a);
    if (zr[d] != 0 && a == 4'd0) return 16'h0000;
    if (byp[d] != 0 && wa_en && wa_addr == a) return wa_data;
    if (byp[d] != 0 && wb_en && wb_addr == a) return wb_data;
    return mReg[d][a];
  endfunction

  function automatic logic expBusy(int d, logic [3:0] a);
    if (byp[d] != 0 && ((wa_en && wa_addr == a) || (wb_en && wb_addr == a)) &&
        !(sb_set && sb_addr == a)) return 1'b0;
    return mBusy[d][a];
  endfunction

  function automatic void commit(int d);
    bit aLive, bLive, clash;
    aLive = wa_en && !(zr[d] != 0 && wa_addr == 4'd0);
    bLive = wb_en && !(zr[d] != 0 && wb_addr == 4'd0);
    clash = aLive && bLive && (wa_addr == wb_addr);
    if (bLive && !clash) mReg[d][wb_addr] = wb_data;
    if (aLive) mReg[d][wa_addr] = wa_data;
    if (wa_en) mBusy[d][wa_addr] = 1'b0;
    if (wb_en) mBusy[d][wb_addr] = 1'b0;
    if (sb_set) mBusy[d][sb_addr] = 1'b1;
    if (zr[d] != 0) mBusy[d][0] = 1'b0;
    mConf[d] = clash;
  endfunction

  function automatic logic [15:0] getData(int d, int k);
    return (d == 0) ? rdDataA[k*16 +: 16] : rdDataB[k*16 +: 16];
  endfunction

  function automatic logic getBusy(int d, int k);
    return (d == 0) ? rdBusyA[k] : rdBusyB[k];
  endfunction

  task automatic idle();
    wa_en = 0; wb_en = 0; sb_set = 0;
    wa_addr = 0; wb_addr = 0; sb_addr = 0;
    wa_data = 0; wb_data = 0;
  endtask

  task automatic tick();
    if (rst) begin
      commit(0);
      commit(1);
    end else modelReset();
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    rdAddr = {4'd12, 4'd2, 4'd1};
    modelReset();
    repeat (2) @(negedge clk);
    #1;
    nChecks++; if (rdDataA[15:0]  !== 16'hFFFF) begin nFail++; $display("FAIL reset_r1 got %h want FFFF", rdDataA[15:0]); end
    nChecks++; if (rdDataA[31:16] !== 16'h0050) begin nFail++; $display("FAIL reset_r2 got %h want 0050", rdDataA[31:16]); end
    nChecks++; if (rdDataA[47:32] !== 16'hCCCC) begin nFail++; $display("FAIL reset_r12 got %h want CCCC", rdDataA[47:32]); end
    nChecks++; if (rdDataB !== rdDataA) begin nFail++; $display("FAIL reset_dutB_reads got %h want %h", rdDataB, {16'hCCCC, 16'h0050, 16'hFFFF}); end
    nChecks++; if (cntA !== 5'd0 || cntB !== 5'd0) begin nFail++; $display("FAIL reset_busy_cnt got %0d/%0d want 0", cntA, cntB); end
    nChecks++; if (confA !== 1'b0 || rdBusyA !== 3'b000) begin nFail++; $display("FAIL reset_flags got conf %b busy %b want 0/000", confA, rdBusyA); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_write_bypass();
    @(negedge clk);
    idle();
    wa_en = 1; wa_addr = 4'd5; wa_data = 16'h1234;
    rdAddr = {4'd0, 4'd0, 4'd5};
    #1;
    nChecks++; if (rdDataA[15:0] !== 16'h1234) begin nFail++; $display("FAIL bypass_on got %h want 1234", rdDataA[15:0]); end
    nChecks++; if (rdDataB[15:0] !== 16'h0040) begin nFail++; $display("FAIL bypass_off got %h want 0040", rdDataB[15:0]); end
    tick();
    @(negedge clk);
    idle();
    #1;
    nChecks++; if (rdDataB[15:0] !== 16'h1234) begin nFail++; $display("FAIL write_visible got %h want 1234", rdDataB[15:0]); end
  endtask

  task automatic test_conflict();
    @(negedge clk);
    wa_en = 1; wa_addr = 4'd7; wa_data = 16'hAAAA;
    wb_en = 1; wb_addr = 4'd7; wb_data = 16'hBBBB;
    rdAddr = {4'd0, 4'd0, 4'd7};
    #1;
    nChecks++; if (rdDataA[15:0] !== 16'hAAAA) begin nFail++; $display("FAIL conflict_bypass got %h want AAAA", rdDataA[15:0]); end
    tick();
    @(negedge clk);
    idle();
    #1;
    nChecks++; if (rdDataA[15:0] !== 16'hAAAA || rdDataB[15:0] !== 16'hAAAA) begin nFail++; $display("FAIL conflict_r7 got %h/%h want AAAA", rdDataA[15:0], rdDataB[15:0]); end
    nChecks++; if (confA !== 1'b1 || confB !== 1'b1) begin nFail++; $display("FAIL conflict_pulse got %b/%b want 1", confA, confB); end
    tick();
    @(negedge clk);
    #1;
    nChecks++; if (confA !== 1'b0 || confB !== 1'b0) begin nFail++; $display("FAIL conflict_one_cycle got %b/%b want 0", confA, confB); end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    idle();
    sb_set = 1; sb_addr = 4'd3;
    rdAddr = {4'd0, 4'd0, 4'd3};
    tick();
    @(negedge clk);
    idle();
    wb_en = 1; wb_addr = 4'd3; wb_data = 16'h5555;
    #1;
    nChecks++; if (rdBusyB[0] !== 1'b1 || cntA !== 5'd1 || cntB !== 5'd1) begin nFail++; $display("FAIL sb_set got busy %b cnt %0d/%0d want 1 1/1", rdBusyB[0], cntA, cntB); end
    nChecks++; if (rdBusyA[0] !== 1'b0) begin nFail++; $display("FAIL sb_bypass_clear got %b want 0", rdBusyA[0]); end
    tick();
    @(negedge clk);
    idle();
    sb_set = 1; sb_addr = 4'd3;
    wa_en = 1; wa_addr = 4'd3; wa_data = 16'h7777;
    #1;
    nChecks++; if (rdBusyA[0] !== 1'b0 || cntA !== 5'd0 || cntB !== 5'd0) begin nFail++; $display("FAIL sb_clear got busy %b cnt %0d/%0d want 0 0/0", rdBusyA[0], cntA, cntB); end
    tick();
    @(negedge clk);
    idle();
    #1;
    nChecks++; if (rdBusyA[0] !== 1'b1 || rdBusyB[0] !== 1'b1 || cntA !== 5'd1) begin nFail++; $display("FAIL sb_set_wins got %b/%b cnt %0d want 1/1 1", rdBusyA[0], rdBusyB[0], cntA); end
    nChecks++; if (rdDataB[15:0] !== 16'h7777) begin nFail++; $display("FAIL sb_r3_updated got %h want 7777", rdDataB[15:0]); end
    wa_en = 1; wa_addr = 4'd3; wa_data = 16'h7777;
    tick();
  endtask

  task automatic test_zero_r0();
    @(negedge clk);
    idle();
    wa_en = 1; wa_addr = 4'd0; wa_data = 16'hFFFF;
    sb_set = 1; sb_addr = 4'd0;
    rdAddr = {4'd0, 4'd0, 4'd0};
    #1;
    nChecks++; if (rdDataB[15:0] !== 16'h0000 || rdBusyB[0] !== 1'b0) begin nFail++; $display("FAIL zero_r0_comb got %h busy %b want 0000 0", rdDataB[15:0], rdBusyB[0]); end
    tick();
    @(negedge clk);
    idle();
    #1;
    nChecks++; if (rdDataB[15:0] !== 16'h0000 || rdBusyB[0] !== 1'b0 || cntB !== 5'd0) begin nFail++; $display("FAIL zero_r0_reg got %h busy %b cnt %0d want 0000 0 0", rdDataB[15:0], rdBusyB[0], cntB); end
    nChecks++; if (rdDataA[15:0] !== 16'hFFFF || cntA !== 5'd1) begin nFail++; $display("FAIL r0_normal got %h cnt %0d want FFFF 1", rdDataA[15:0], cntA); end
    wa_en = 1; wa_addr = 4'd0; wa_data = 16'h0000;
    tick();
  endtask

  task automatic test_reset_midstream();
    logic [3:0] busyAddrs [4] = '{4'd9, 4'd10, 4'd11, 4'd13};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle();
      sb_set = 1; sb_addr = busyAddrs[i];
      tick();
    end
    @(negedge clk);
    idle();
    #1;
    nChecks++; if (cntA !== 5'd4 || cntB !== 5'd4) begin nFail++; $display("FAIL pre_reset_cnt got %0d/%0d want 4", cntA, cntB); end
    wa_en = 1; wa_addr = 4'd1; wa_data = 16'hDEAD;
    wb_en = 1; wb_addr = 4'd1; wb_data = 16'hBEEF;
    sb_set = 1; sb_addr = 4'd14;
    rdAddr = {4'd8, 4'd13, 4'd12};
    #1;
    rst = 1'b0;
    modelReset();
    #1;
    nChecks++; if (rdDataA !== {16'h8888, 16'h0002, 16'hCCCC} || rdDataB !== {16'h8888, 16'h0002, 16'hCCCC}) begin nFail++; $display("FAIL midreset_image got %h/%h want 88880002cccc", rdDataA, rdDataB); end
    nChecks++; if (cntA !== 5'd0 || cntB !== 5'd0 || rdBusyB[1] !== 1'b0) begin nFail++; $display("FAIL midreset_busy got cnt %0d/%0d busy13 %b want 0/0 0", cntA, cntB, rdBusyB[1]); end
    nChecks++; if (confA !== 1'b0 || confB !== 1'b0) begin nFail++; $display("FAIL midreset_conf got %b/%b want 0", confA, confB); end
    tick();
    @(negedge clk);
    rst = 1'b1;
    idle();
    rdAddr = {4'd14, 4'd0, 4'd1};
    #1;
    nChecks++; if (rdDataA[15:0] !== 16'hFFFF || rdDataB[15:0] !== 16'hFFFF) begin nFail++; $display("FAIL midreset_discard got %h/%h want FFFF", rdDataA[15:0], rdDataB[15:0]); end
    nChecks++; if (rdBusyA[2] !== 1'b0 || confA !== 1'b0) begin nFail++; $display("FAIL midreset_after got busy14 %b conf %b want 0 0", rdBusyA[2], confA); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 400; it++) begin
      @(negedge clk);
      wa_en = ($urandom_range(0, 1) == 1);
      wb_en = ($urandom_range(0, 1) == 1);
      sb_set = ($urandom_range(0, 2) == 0);
      wa_addr = wa_en ? 4'($urandom_range(0, 15)) : 4'bx;
      wb_addr = wb_en ? (($urandom_range(0, 3) == 0 && wa_en) ? wa_addr : 4'($urandom_range(0, 15))) : 4'bx;
      sb_addr = sb_set ? 4'($urandom_range(0, 15)) : 4'bx;
      wa_data = 16'($urandom);
      wb_data = 16'($urandom);
      rdAddr = 12'($urandom);
      #1;
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < 3; k++) begin
          nChecks++;
          if (getData(d, k) !== expRead(d, rdAddr[k*4 +: 4])) begin
            nFail++;
            $display("FAIL rand_data it%0d dut%0d port%0d got %h want %h", it, d, k, getData(d, k), expRead(d, rdAddr[k*4 +: 4]));
          end
          nChecks++;
          if (getBusy(d, k) !== expBusy(d, rdAddr[k*4 +: 4])) begin
            nFail++;
            $display("FAIL rand_busy it%0d dut%0d port%0d got %b want %b", it, d, k, getBusy(d, k), expBusy(d, rdAddr[k*4 +: 4]));
          end
        end
      end
      nChecks++;
      if (int'(cntA) != modelCount(0) || int'(cntB) != modelCount(1)) begin
        nFail++;
        $display("FAIL rand_cnt it%0d got %0d/%0d want %0d/%0d", it, cntA, cntB, modelCount(0), modelCount(1));
      end
      nChecks++;
      if (confA !== mConf[0] || confB !== mConf[1]) begin
        nFail++;
        $display("FAIL rand_conf it%0d got %b/%b want %b/%b", it, confA, confB, mConf[0], mConf[1]);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_conflict();
    test_scoreboard();
    test_zero_r0();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
